// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-32 core with one shared instruction/data port; 3-5 cycles per instruction plus memory wait cycles.
// Each request is held with a stable address and data until mem_ready; reset is the only way to drop one early.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TEST_REG = 2,
  parameter int unsigned TEST_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [TEST_W-1:0] test_value,
  output logic              trap
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t state, state_nxt;

  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] alu_res;
  logic        funct_ok;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign test_value = rf[5'(TEST_REG)][TEST_W-1:0];
  assign trap       = (state == S_TRAP);

  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_res = a + b;
      FN_SUB:  alu_res = a - b;
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_SLT:  alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: funct_ok = 1'b0;
    endcase
  end

  // Bus outputs are forced idle while reset is asserted, independent of state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (RST) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_MEMREAD: begin
          mem_req  = 1'b1;
          mem_addr = alu_out;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = alu_out;
          mem_wdata = b;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:              state_nxt = S_EXEC;
          OP_LW, OP_SW, OP_ADDI: state_nxt = S_MEMADR;
          OP_BEQ:                state_nxt = S_BRANCH;
          OP_J:                  state_nxt = S_JUMP;
          default:               state_nxt = S_TRAP;
        endcase
      end
      S_EXEC:     state_nxt = funct_ok ? S_ALUWB : S_TRAP;
      S_MEMADR: begin
        if (opcode == OP_LW)      state_nxt = S_MEMREAD;
        else if (opcode == OP_SW) state_nxt = S_MEMWRITE;
        else                      state_nxt = S_ADDIWB;
      end
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_ALUWB, S_MEMWB, S_ADDIWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc + (imm_sext << 2);
        end
        S_EXEC:     if (funct_ok) alu_out <= alu_res;
        S_ALUWB:    if (rd != 5'd0) rf[rd] <= alu_out;
        S_MEMADR:   alu_out <= a + imm_sext;
        S_MEMREAD:  if (mem_ready) mdr <= mem_rdata;
        S_MEMWB:    if (rt != 5'd0) rf[rt] <= mdr;
        S_ADDIWB:   if (rt != 5'd0) rf[rt] <= alu_out;
        S_BRANCH:   if (a == b) pc <= alu_out;
        S_JUMP:     pc <= {pc[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed and random programs run against an instruction-level model
// that predicts every bus transfer (cycle, address, direction, data), the trap cycle and test_value.
module tb_mips_multicycle_core;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] TRAPW = 32'hFC00_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        mem_req, mem_we, trap;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] test_value;

  mips_multicycle_core #(.RESET_PC(RPC), .TEST_REG(2), .TEST_W(16)) dut (
    .CLK(CLK), .RST(RST), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .test_value(test_value), .trap(trap)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rel0  = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Shared RAM plus a responder whose wait count per access comes from waits[].
  logic [31:0] mem [1024];
  int          waits [256];
  int          acc_idx = 0;
  int          wcnt = 0;
  logic [31:0] hold_addr, hold_wd;
  logic        hold_we;
  int          act_cyc[$];
  logic [31:0] act_addr[$], act_wd[$];
  logic        act_we[$];

  always @(negedge CLK) begin
    if (mem_req === 1'b1) begin
      if (wcnt > 0) chk("hold_stable", {mem_we, mem_addr, mem_wdata[30:0]}, {hold_we, hold_addr, hold_wd[30:0]});
      hold_addr = mem_addr;
      hold_we   = mem_we;
      hold_wd   = mem_wdata;
      mem_rdata = mem[mem_addr[11:2]];
      mem_ready = (wcnt >= waits[acc_idx % 256]);
      if (mem_ready) begin
        act_cyc.push_back(cyc - rel0);
        act_addr.push_back(mem_addr);
        act_we.push_back(mem_we);
        act_wd.push_back(mem_wdata);
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        acc_idx++;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] tg);
    return {6'h02, tg};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = (i >= 512 && i < 576) ? $urandom : 32'h0;
  endtask

  task automatic set_waits(input int lo, input int hi);
    for (int i = 0; i < 256; i++) waits[i] = int'($urandom_range(hi, lo));
  endtask

  // Instruction-level reference: architectural effect plus the cycle cost of each instruction class.
  logic [31:0] mref [1024];
  logic [31:0] rfm [32];
  int          exp_cyc[$];
  logic [31:0] exp_addr[$], exp_wd[$];
  logic        exp_we[$];
  int          exp_trap;

  task automatic push_exp(input int c, input logic [31:0] ad, input logic we, input logic [31:0] d);
    exp_cyc.push_back(c);
    exp_addr.push_back(ad);
    exp_we.push_back(we);
    exp_wd.push_back(d);
  endtask

  task automatic run_model();
    logic [31:0] pc, ins, se, ea, x, y;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    int          t, f, acc;
    bit          done;
    mref = mem;
    for (int i = 0; i < 32; i++) rfm[i] = '0;
    exp_cyc.delete(); exp_addr.delete(); exp_we.delete(); exp_wd.delete();
    pc = RPC; t = 0; acc = 0; exp_trap = -1; done = 1'b0;
    for (int n = 0; n < 500; n++) begin
      f = t + waits[acc % 256]; acc++;
      push_exp(f, pc, 1'b0, 32'h0);
      ins = mref[pc[11:2]];
      pc  = pc + 32'd4;
      op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      se = {{16{ins[15]}}, ins[15:0]};
      x = rfm[rs]; y = rfm[rt];
      ea = x + se;
      t = f + 4;
      case (op)
        6'h00: begin
          case (fn)
            6'h20: rfm[rd] = x + y;
            6'h22: rfm[rd] = x - y;
            6'h24: rfm[rd] = x & y;
            6'h25: rfm[rd] = x | y;
            6'h2A: rfm[rd] = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: begin exp_trap = f + 3; done = 1'b1; end
          endcase
        end
        6'h08: rfm[rt] = ea;
        6'h23: begin
          f = f + 3 + waits[acc % 256]; acc++;
          push_exp(f, ea, 1'b0, 32'h0);
          rfm[rt] = mref[ea[11:2]];
          t = f + 2;
        end
        6'h2B: begin
          f = f + 3 + waits[acc % 256]; acc++;
          push_exp(f, ea, 1'b1, y);
          mref[ea[11:2]] = y;
          t = f + 1;
        end
        6'h04: begin
          if (x == y) pc = pc + (se << 2);
          t = f + 3;
        end
        6'h02: begin
          pc = {pc[31:28], ins[25:0], 2'b00};
          t = f + 3;
        end
        default: begin exp_trap = f + 2; done = 1'b1; end
      endcase
      rfm[0] = '0;
      if (done) break;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("rst_req", 64'(mem_req), 64'h0);
      chk("rst_bus", {mem_we, mem_addr, mem_wdata[30:0]}, 64'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    rel0 = cyc; acc_idx = 0; wcnt = 0;
    act_cyc.delete(); act_addr.delete(); act_we.delete(); act_wd.delete();
    @(negedge CLK);
    chk("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, RPC});
    chk("rst_trap", 64'(trap), 64'h0);
    chk("rst_test_value", 64'(test_value), 64'h0);
  endtask

  task automatic run_check(input string tag);
    int tc, n;
    run_model();
    do_reset(2);
    tc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (trap === 1'b1) begin tc = cyc - rel0; break; end
    end
    chk({tag, " trap_cycle"}, 64'(tc), 64'(exp_trap));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk({tag, " idle_after_trap"}, {mem_req, trap}, 64'h1);
    end
    chk({tag, " xfer_count"}, 64'(act_addr.size()), 64'(exp_addr.size()));
    n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s xfer%0d cycle", tag, i), 64'(act_cyc[i]), 64'(exp_cyc[i]));
      chk($sformatf("%s xfer%0d we/addr", tag, i), {act_we[i], act_addr[i]}, {exp_we[i], exp_addr[i]});
      chk($sformatf("%s xfer%0d wdata", tag, i), 64'(act_wd[i]), 64'(exp_wd[i]));
    end
    chk({tag, " test_value"}, 64'(test_value), 64'(rfm[2][15:0]));
  endtask

  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  task automatic gen_random();
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int          rem, off, k;
    clear_mem();
    for (int i = 0; i < 14; i++) begin
      pc  = RPC + 32'(4 * i);
      rem = 13 - i;
      rs  = 5'($urandom_range(7, 0));
      rt  = 5'($urandom_range(7, 0));
      rd  = 5'($urandom_range(7, 0));
      off = int'($urandom_range((rem > 2) ? 2 : rem, 0));
      imm = 16'(32'h800 + 4 * $urandom_range(15, 0) + $urandom_range(3, 0));
      k   = int'($urandom_range(6, 0));
      case (k)
        0: put(pc, enc_i(6'h08, rs, rt, 16'($urandom)));
        2: put(pc, enc_i(6'h23, 5'd0, rt, imm));
        3: put(pc, enc_i(6'h2B, 5'd0, rt, imm));
        4: put(pc, enc_i(6'h04, rs, rt, 16'(off)));
        5: put(pc, enc_j(26'((pc + 32'd4 + 32'(4 * off)) >> 2)));
        default: put(pc, enc_r(rs, rt, rd, fn_tab[$urandom_range(4, 0)]));
      endcase
    end
    // Dump $1..$7 so every register value shows up as write data on the bus.
    for (int r = 1; r < 8; r++)
      put(RPC + 32'(56 + 4 * (r - 1)), enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h900 + 4 * r)));
    put(RPC + 32'd84, TRAPW);
    set_waits(0, 2);
  endtask

  initial begin
    // ALU sequence, zero waits.
    clear_mem(); set_waits(0, 0);
    put(RPC + 0,  enc_i(6'h08, 5'd0, 5'd2, 16'd5));
    put(RPC + 4,  enc_i(6'h08, 5'd0, 5'd3, 16'hFFFD));
    put(RPC + 8,  enc_r(5'd2, 5'd3, 5'd2, 6'h20));
    put(RPC + 12, enc_r(5'd3, 5'd2, 5'd4, 6'h2A));
    put(RPC + 16, enc_i(6'h2B, 5'd0, 5'd4, 16'h0800));
    put(RPC + 20, TRAPW);
    run_check("alu");
    chk("alu test_value", 64'(test_value), 64'h2);
    chk("alu slt result", 64'(act_wd[5]), 64'h1);
    chk("alu spacing", 64'(act_cyc[3] - act_cyc[2]), 64'd4);

    // Memory with 3 wait cycles on every access.
    clear_mem(); set_waits(3, 3);
    put(RPC + 0,  enc_i(6'h08, 5'd0, 5'd2, 16'd2));
    put(RPC + 4,  enc_i(6'h2B, 5'd0, 5'd2, 16'd8));
    put(RPC + 8,  enc_i(6'h23, 5'd0, 5'd5, 16'd8));
    put(RPC + 12, enc_i(6'h2B, 5'd0, 5'd5, 16'h0800));
    put(RPC + 16, TRAPW);
    run_check("memwait");
    chk("memwait sw", {act_we[2], act_addr[2], act_wd[2][15:0]}, {1'b1, 32'h8, 16'h2});
    chk("memwait lw value", 64'(act_wd[6]), 64'h2);
    chk("memwait lw cycles", 64'(act_cyc[5] - act_cyc[3]), 64'd11);

    // Control flow: taken beq, jump, untaken beq.
    clear_mem(); set_waits(0, 0);
    put(RPC + 0,     enc_i(6'h04, 5'd0, 5'd0, 16'd2));
    put(RPC + 12,    enc_j(26'h50));
    put(32'h140,     enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    put(32'h144,     enc_i(6'h08, 5'd0, 5'd2, 16'd3));
    put(32'h148,     enc_i(6'h04, 5'd1, 5'd2, 16'd5));
    put(32'h14C,     TRAPW);
    run_check("ctrl");
    chk("ctrl beq target", 64'(act_addr[1]), 64'h10C);
    chk("ctrl beq cycles", 64'(act_cyc[1] - act_cyc[0]), 64'd3);
    chk("ctrl jump target", 64'(act_addr[2]), 64'h140);
    chk("ctrl fallthrough", 64'(act_addr[5]), 64'h14C);

    // Writes to $0 dropped, then an unsupported opcode.
    clear_mem(); set_waits(0, 1);
    put(RPC + 0, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
    put(RPC + 4, enc_i(6'h2B, 5'd0, 5'd0, 16'h0800));
    put(RPC + 8, TRAPW);
    run_check("zero_reg");
    chk("zero_reg value", 64'(act_wd[2]), 64'h0);

    // Unsupported funct traps from EXEC.
    clear_mem(); set_waits(0, 0);
    put(RPC + 0, enc_i(6'h08, 5'd0, 5'd2, 16'h1234));
    put(RPC + 4, enc_r(5'd2, 5'd2, 5'd2, 6'h21));
    run_check("bad_funct");

    // Reset while a load is waiting for ready.
    clear_mem();
    for (int i = 0; i < 256; i++) waits[i] = 30;
    waits[0] = 0;
    put(RPC + 0, enc_i(6'h23, 5'd0, 5'd2, 16'h0800));
    put(RPC + 4, TRAPW);
    put(32'h800, 32'h1234_5678);
    do_reset(2);
    repeat (6) @(negedge CLK);
    chk("rst_mid pending", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h800});
    run_check("rst_mid");
    chk("rst_mid load", 64'(test_value), 64'h5678);

    for (int r = 0; r < 6; r++) begin
      gen_random();
      run_check($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle MIPS-32 core: the next generation of the single-cycle top level. Control is an FSM, and one shared memory port carries both instruction fetch and data traffic through a req/ready handshake with arbitrary wait states. Adds a configurable reset vector, a configurable debug-register export, and a sticky trap on unsupported opcodes. Sits at the top of the design; the instruction/data RAM is external and shared.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TEST_REG, 2: register-file index exported on test_value.
- TEST_W, 16: width of test_value (1..32).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  32  byte address; valid while mem_req = 1.
- mem_wdata  out  32  write data; valid while mem_req = 1 and mem_we = 1.
- mem_rdata  in  32  read data; sampled only in the cycle where mem_req = 1 and mem_ready = 1.
- mem_ready  in  1  transfer completes in any cycle where mem_req = 1 and mem_ready = 1.
- test_value  out  TEST_W  RF[TEST_REG][TEST_W-1:0], combinational from the register file.
- trap  out  1  sticky; set on an unsupported opcode or funct.

## Operation
- Supported ISA:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Internal registers: PC, IR, MDR, A, B, ALUOut, and a 32x32 register file.
- Register file: $0 always reads 0; writes to $0 are dropped.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stay until mem_ready. On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=RF[rs], B<=RF[rt], ALUOut<=PC+(signext(imm)<<2). Dispatch on opcode: R-type→EXEC; lw/sw/addi→MEMADR; beq→BRANCH; j→JUMP; any other opcode→TRAP.
  - EXEC: ALUOut<=A op B; go to ALUWB. An unsupported funct goes to TRAP instead.
  - ALUWB: RF[rd]<=ALUOut; go to FETCH.
  - MEMADR: ALUOut<=A+signext(imm). lw→MEMREAD, sw→MEMWRITE, addi→ADDIWB.
  - MEMREAD: mem_req=1, mem_we=0, mem_addr=ALUOut. On ready: MDR<=mem_rdata, go to MEMWB.
  - MEMWB: RF[rt]<=MDR; go to FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. On ready: go to FETCH.
  - ADDIWB: RF[rt]<=ALUOut; go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut; go to FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; go to FETCH.
  - TRAP: trap=1, mem_req=0. No register or memory writes. Held until reset.
- Arithmetic and width rules:
  - add/sub/addi wrap modulo 2^32; no overflow exception.
  - slt is a signed compare, result 0 or 1.
  - Immediates are sign-extended.
  - mem_addr is passed unaligned; the low bits are not masked.
- mem_addr, mem_we and mem_wdata are held stable across wait cycles while mem_req = 1.
- mem_req is never dropped before mem_ready arrives, except by reset.

## Timing
- Reset (RST=0 at a rising edge):
  - state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 registers=0, trap=0.
  - While RST=0, mem_req is forced to 0; mem_we=0, mem_addr=0, mem_wdata=0.
- The first fetch is requested in the first cycle with RST=1.
- Reset mid-transfer aborts it: no RF write, no IR/MDR update. The memory must tolerate mem_req dropping without ready.
- Cycles per instruction with zero wait states (ready high in the request cycle): R-type 4, lw 5, sw 4, addi 4, beq 3, j 3. Each wait cycle adds 1 per memory access.
- RF writes take effect at the end of the writeback cycle and are visible to the next instruction's DECODE.
- test_value reflects the write in the cycle after the writeback edge.
- PC+4 in FETCH and the branch target in DECODE both use the PC value at the start of that state.
- trap rises in the cycle after the DECODE/EXEC edge that detected the fault.

## Test plan
- Reset: RST=0 for 2 cycles, then release, RESET_PC=32'h100 → mem_req=0 during reset; first request has mem_addr=0x100, mem_we=0; test_value=0.
- ALU sequence, zero wait states: addi $2,$0,5; addi $3,$0,-3; add $2,$2,$3; slt $4,$3,$2 → test_value=0x0002, RF[4]=1; instruction-to-instruction spacing 4 cycles each.
- Memory with waits, ready delayed 3 cycles on every access: sw $2,8($0) then lw $5,8($0) → single write to addr 8 with wdata=2, held stable across waits; RF[5]=2; lw occupies 5+6=11 cycles.
- Control flow: beq $0,$0,+2 at PC 0x0 → next fetch 0x0C after 3 cycles; j 0x40 → next fetch 0x100; beq with unequal operands falls through to PC+4.
- $0 and trap: addi $0,$0,7, then an opcode 111111 word → RF[0] still reads 0; trap=1 two cycles after that fetch completes; no further mem_req; RST clears trap.
- Reset during MEMREAD wait: RST=0 while lw is pending → no RF write, mem_req=0; after release, fetch restarts at RESET_PC.
